ddr_mem_responder: RTL and testbench

- Memory-side responder for the DDR request interface driven by the channel arbiter in the simulation memory subsystem.
- Accepts one-cycle chip-enable request pulses and serves them against a 64-bit-wide synchronous backing RAM.
- A burst access moves one 512-bit line as 8 beats; a single access moves one 64-bit word.
- Reports completion with a one-cycle operation-done pulse and deasserts ready while busy.

---
 rtl/ddr_mem_responder.sv | 178 +++++++++++++++++
 tb/tb_ddr_mem_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_mem_responder.sv
// DDR request responder: serves chip-enable requests against a 64-bit synchronous backing RAM.
// Optional statistics outputs are built in when DDR_RESP_STATS_EN is defined.
module ddr_mem_responder #(
    parameter int unsigned ACCESS_LATENCY = 4,
    parameter int unsigned RAM_AW         = 20,
    parameter int unsigned BEATS          = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  ddr_chip_enable,
    input  logic [63:0]           ddr_index,
    input  logic                  ddr_write_enable,
    input  logic                  ddr_burst_mode,
    input  logic [64*BEATS-1:0]   ddr_write_data,
    output logic [64*BEATS-1:0]   ddr_read_data,
    output logic                  ddr_operation_done,
    output logic                  ddr_ready,
`ifdef DDR_RESP_STATS_EN
    output logic [31:0]           stat_rd_count,
    output logic [31:0]           stat_wr_count,
    output logic                  stat_ce_while_busy,
`endif
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [RAM_AW-1:0]     ram_addr,
    output logic [63:0]           ram_wdata,
    input  logic [63:0]           ram_rdata
);

    localparam int unsigned LINE_W = 64 * BEATS;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned WAIT_W = (ACCESS_LATENCY < 2) ? 1 : $clog2(ACCESS_LATENCY + 1);

    typedef enum logic [2:0] {StIdle, StWait, StBeat, StDrain, StDone} state_t;

    state_t              state_q;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [BEAT_W-1:0]   next_beat;
    logic [BEAT_W-1:0]   cap_slot_q;
    logic                rd_cap_q;
    logic [RAM_AW-1:0]   base_q;
    logic [RAM_AW-1:0]   acc_base;
    logic                we_q;
    logic                burst_q;
    logic [LINE_W-1:0]   wdata_q;
    logic [LINE_W-1:0]   line_buf_q;
    logic [LINE_W-1:0]   line_buf_next;
    logic                last_beat;
    logic                unused_idx;

    assign ddr_ready  = (state_q == StIdle);
    assign next_beat  = beat_q + 1'b1;
    assign unused_idx = ^{ddr_index[63:RAM_AW+3], ddr_index[2:0]};

    always_comb begin
        acc_base = ddr_index[RAM_AW+2:3];
        // Bursts are line-aligned; the beat counter supplies the low address bits.
        if (ddr_burst_mode && BEATS > 1) begin
            acc_base[BEAT_W-1:0] = '0;
        end
        last_beat = burst_q ? (beat_q == BEAT_W'(BEATS - 1)) : (beat_q == '0);
        line_buf_next = line_buf_q;
        if (rd_cap_q) begin
            line_buf_next[int'(cap_slot_q)*64 +: 64] = ram_rdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q            <= StIdle;
            wait_cnt_q         <= '0;
            beat_q             <= '0;
            cap_slot_q         <= '0;
            rd_cap_q           <= 1'b0;
            base_q             <= '0;
            we_q               <= 1'b0;
            burst_q            <= 1'b0;
            wdata_q            <= '0;
            line_buf_q         <= '0;
            ddr_read_data      <= '0;
            ddr_operation_done <= 1'b0;
            ram_en             <= 1'b0;
            ram_we             <= 1'b0;
            ram_addr           <= '0;
            ram_wdata          <= '0;
        end else begin
            ddr_operation_done <= 1'b0;
            rd_cap_q           <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (ddr_chip_enable) begin
                        base_q     <= acc_base;
                        we_q       <= ddr_write_enable;
                        burst_q    <= ddr_burst_mode;
                        wdata_q    <= ddr_write_data;
                        line_buf_q <= '0;
                        beat_q     <= '0;
                        if (ACCESS_LATENCY == 0) begin
                            // No wait phase: issue beat 0 straight from the request inputs.
                            state_q   <= StBeat;
                            ram_en    <= 1'b1;
                            ram_we    <= ddr_write_enable;
                            ram_addr  <= acc_base;
                            ram_wdata <= ddr_write_enable ? ddr_write_data[63:0] : '0;
                        end else begin
                            state_q    <= StWait;
                            wait_cnt_q <= WAIT_W'(ACCESS_LATENCY);
                        end
                    end
                end
                StWait: begin
                    wait_cnt_q <= wait_cnt_q - 1'b1;
                    if (wait_cnt_q == WAIT_W'(1)) begin
                        state_q   <= StBeat;
                        beat_q    <= '0;
                        ram_en    <= 1'b1;
                        ram_we    <= we_q;
                        ram_addr  <= base_q;
                        ram_wdata <= we_q ? wdata_q[63:0] : '0;
                    end
                end
                StBeat: begin
                    rd_cap_q   <= !we_q;
                    cap_slot_q <= beat_q;
                    if (rd_cap_q) begin
                        line_buf_q <= line_buf_next;
                    end
                    if (last_beat) begin
                        ram_en <= 1'b0;
                        ram_we <= 1'b0;
                        if (we_q) begin
                            state_q            <= StDone;
                            ddr_operation_done <= 1'b1;
                        end else begin
                            state_q <= StDrain;
                        end
                    end else begin
                        beat_q    <= next_beat;
                        ram_addr  <= base_q + RAM_AW'(next_beat);
                        ram_wdata <= we_q ? wdata_q[int'(next_beat)*64 +: 64] : '0;
                    end
                end
                StDrain: begin
                    line_buf_q         <= line_buf_next;
                    ddr_read_data      <= line_buf_next;
                    ddr_operation_done <= 1'b1;
                    state_q            <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef DDR_RESP_STATS_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stat_rd_count      <= '0;
            stat_wr_count      <= '0;
            stat_ce_while_busy <= 1'b0;
        end else if (ddr_chip_enable) begin
            if (!ddr_ready) begin
                stat_ce_while_busy <= 1'b1;
            end else if (ddr_write_enable) begin
                stat_wr_count <= stat_wr_count + 32'd1;
            end else begin
                stat_rd_count <= stat_rd_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ddr_mem_responder.sv
// Directed bench for ddr_mem_responder: DUT a uses ACCESS_LATENCY=4, DUT b uses ACCESS_LATENCY=0.
module tb_ddr_mem_responder;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset_n;
    logic         ce_a, ce_b;
    logic [63:0]  ddr_index;
    logic         ddr_write_enable;
    logic         ddr_burst_mode;
    logic [511:0] ddr_write_data;

    logic [511:0] rd_a, rd_b;
    logic         done_a, done_b, ready_a, ready_b, en_a, en_b, we_a, we_b;
    logic [19:0]  addr_a, addr_b;
    logic [63:0]  wdata_a, wdata_b, rdata_a, rdata_b;
`ifdef DDR_RESP_STATS_EN
    logic [31:0]  rdc_a, wrc_a, rdc_b, wrc_b;
    logic         busy_a, busy_b;
    int           rd0;
`endif

    ddr_mem_responder #(.ACCESS_LATENCY(4), .RAM_AW(20), .BEATS(8)) dut_a (
        .clock(clock), .reset_n(reset_n), .ddr_chip_enable(ce_a), .ddr_index(ddr_index),
        .ddr_write_enable(ddr_write_enable), .ddr_burst_mode(ddr_burst_mode),
        .ddr_write_data(ddr_write_data), .ddr_read_data(rd_a), .ddr_operation_done(done_a),
        .ddr_ready(ready_a),
`ifdef DDR_RESP_STATS_EN
        .stat_rd_count(rdc_a), .stat_wr_count(wrc_a), .stat_ce_while_busy(busy_a),
`endif
        .ram_en(en_a), .ram_we(we_a), .ram_addr(addr_a), .ram_wdata(wdata_a),
        .ram_rdata(rdata_a)
    );

    ddr_mem_responder #(.ACCESS_LATENCY(0), .RAM_AW(20), .BEATS(8)) dut_b (
        .clock(clock), .reset_n(reset_n), .ddr_chip_enable(ce_b), .ddr_index(ddr_index),
        .ddr_write_enable(ddr_write_enable), .ddr_burst_mode(ddr_burst_mode),
        .ddr_write_data(ddr_write_data), .ddr_read_data(rd_b), .ddr_operation_done(done_b),
        .ddr_ready(ready_b),
`ifdef DDR_RESP_STATS_EN
        .stat_rd_count(rdc_b), .stat_wr_count(wrc_b), .stat_ce_while_busy(busy_b),
`endif
        .ram_en(en_b), .ram_we(we_b), .ram_addr(addr_b), .ram_wdata(wdata_b),
        .ram_rdata(rdata_b)
    );

    // Synchronous RAM models: read data appears the cycle after the strobe.
    logic [63:0] mem_a [0:4095];
    logic [63:0] mem_b [0:4095];
    always @(posedge clock) begin
        if (en_a) begin
            if (we_a) mem_a[addr_a[11:0]] <= wdata_a;
            else      rdata_a <= mem_a[addr_a[11:0]];
        end
        if (en_b) begin
            if (we_b) mem_b[addr_b[11:0]] <= wdata_b;
            else      rdata_b <= mem_b[addr_b[11:0]];
        end
    end

    logic        sel;
    logic        c_ready, c_done, c_en, c_we;
    logic [19:0] c_addr;
    logic [63:0] c_wdata;
    assign c_ready = sel ? ready_b : ready_a;
    assign c_done  = sel ? done_b  : done_a;
    assign c_en    = sel ? en_b    : en_a;
    assign c_we    = sel ? we_b    : we_a;
    assign c_addr  = sel ? addr_b  : addr_a;
    assign c_wdata = sel ? wdata_b : wdata_a;

    logic        s_ready [0:31];
    logic [19:0] s_addr  [0:31];
    logic [63:0] s_wdata [0:31];
    int done_cyc, done_cnt, en_cnt, we_cnt, first_en, last_en, nrdy;
    int n_cmp, n_fail;
    logic [511:0] line_a, line_b, line_c;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request; cycle k is observed 1 time unit after the k-th edge past acceptance.
    task automatic op(input logic s, input logic we, input logic burst, input logic [63:0] idx,
                      input logic [511:0] wd, input int inj, input int rst);
        sel = s;
        @(negedge clock);
        ddr_index        = idx;
        ddr_write_enable = we;
        ddr_burst_mode   = burst;
        ddr_write_data   = wd;
        if (s) ce_b = 1'b1; else ce_a = 1'b1;
        @(posedge clock); #1;
        ce_a = 1'b0; ce_b = 1'b0;
        done_cyc = -1; done_cnt = 0; en_cnt = 0; we_cnt = 0; first_en = -1; last_en = -1;
        for (int k = 1; k <= 30; k++) begin
            s_ready[k] = c_ready;
            s_addr[k]  = c_addr;
            s_wdata[k] = c_wdata;
            if (c_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (c_en) begin
                en_cnt++;
                if (c_we) we_cnt++;
                if (first_en < 0) first_en = k;
                last_en = k;
            end
            if (k == inj) begin
                if (s) ce_b = 1'b1; else ce_a = 1'b1;
                ddr_write_enable = ~we;
                ddr_index        = 64'h0000_0000_0003_0000;
            end
            if (k == rst) reset_n = 1'b0;
            if (done_cyc >= 0 && k == done_cyc + 1) break;
            @(posedge clock); #1;
            ce_a = 1'b0; ce_b = 1'b0; reset_n = 1'b1;
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; sel = 1'b0;
        reset_n = 1'b0; ce_a = 1'b0; ce_b = 1'b0;
        ddr_index = '0; ddr_write_enable = 1'b0; ddr_burst_mode = 1'b0; ddr_write_data = '0;
        for (int k = 0; k < 8; k++) begin
            line_a[64*k +: 64] = 64'h00A0 + 64'(k);
            line_b[64*k +: 64] = 64'hB000 + 64'(k);
            line_c[64*k +: 64] = 64'h5500 + 64'(k);
        end
        repeat (3) @(posedge clock);
        #1;
        check("rst_ready",  ready_a, 1'b1);
        check("rst_done",   done_a, 1'b0);
        check("rst_rdata",  rd_a, '0);
        check("rst_ram_en", en_a, 1'b0);
        check("rst_ram_we", we_a, 1'b0);
        check("rst_addr",   addr_a, '0);
        check("rst_wdata",  wdata_a, '0);
        check("rst_ready_b", ready_b, 1'b1);
        reset_n = 1'b1;

        op(1'b0, 1'b1, 1'b1, 64'h1040, line_a, -1, -1);
        check("wr_done_cyc", done_cyc, 13);
        check("wr_done_cnt", done_cnt, 1);
        check("wr_en_cnt",   en_cnt, 8);
        check("wr_we_cnt",   we_cnt, 8);
        check("wr_first_en", first_en, 5);
        check("wr_last_en",  last_en, 12);
        nrdy = 0;
        for (int k = 1; k <= 13; k++) if (!s_ready[k]) nrdy++;
        check("wr_busy_cycles", nrdy, 13);
        check("wr_ready_after", s_ready[14], 1'b1);
        for (int k = 0; k < 8; k++) begin
            check("wr_addr",  s_addr[5+k], 20'h208 + 20'(k));
            check("wr_wdata", s_wdata[5+k], 64'h00A0 + 64'(k));
        end

        op(1'b0, 1'b0, 1'b1, 64'h1040, '0, -1, -1);
        check("rd_done_cyc", done_cyc, 14);
        check("rd_en_cnt",   en_cnt, 8);
        check("rd_we_cnt",   we_cnt, 0);
        check("rd_first_en", first_en, 5);
        check("rd_line",     rd_a, line_a);

        op(1'b0, 1'b1, 1'b1, 64'h2000, line_c, -1, -1);
        check("wr2_done_cyc", done_cyc, 13);
        check("rd_held",      rd_a, line_a);

        op(1'b0, 1'b0, 1'b0, 64'h1048, '0, -1, -1);
        check("srd_en_cnt",   en_cnt, 1);
        check("srd_first_en", first_en, 5);
        check("srd_addr",     s_addr[5], 20'h209);
        check("srd_done_cyc", done_cyc, 7);
        check("srd_data",     rd_a, 512'h00A1);

        op(1'b0, 1'b0, 1'b1, 64'h0000_0100_0000_1058, '0, -1, -1);
        check("align_addr", s_addr[5], 20'h208);
        check("align_line", rd_a, line_a);

`ifdef DDR_RESP_STATS_EN
        rd0 = int'(rdc_a);
        check("stat_busy_clear", busy_a, 1'b0);
`endif
        op(1'b0, 1'b0, 1'b1, 64'h1040, '0, 7, -1);
        check("busy_done_cyc", done_cyc, 14);
        check("busy_done_cnt", done_cnt, 1);
        check("busy_en_cnt",   en_cnt, 8);
        check("busy_we_cnt",   we_cnt, 0);
        check("busy_line",     rd_a, line_a);
`ifdef DDR_RESP_STATS_EN
        check("stat_busy_set", busy_a, 1'b1);
        check("stat_rd_inc",   rdc_a, 32'(rd0 + 1));
        check("stat_wr_cnt",   wrc_a, 32'd2);
`endif

        op(1'b0, 1'b0, 1'b1, 64'h1040, '0, -1, 2);
        check("abort_ready",    s_ready[3], 1'b1);
        check("abort_done_cnt", done_cnt, 0);
        check("abort_en_cnt",   en_cnt, 0);
        check("abort_rdata",    rd_a, '0);
        op(1'b0, 1'b0, 1'b0, 64'h1048, '0, -1, -1);
        check("post_done_cyc", done_cyc, 7);
        check("post_data",     rd_a, 512'h00A1);
`ifdef DDR_RESP_STATS_EN
        check("stat_busy_rst", busy_a, 1'b0);
        check("stat_rd_rst",   rdc_a, 32'd1);
`endif

        op(1'b1, 1'b1, 1'b1, 64'h47, line_b, -1, -1);
        check("l0_wr_first_en", first_en, 1);
        check("l0_wr_done_cyc", done_cyc, 9);
        check("l0_wr_we_cnt",   we_cnt, 8);
        op(1'b1, 1'b0, 1'b1, 64'h40, '0, -1, -1);
        check("l0_rd_first_en", first_en, 1);
        check("l0_rd_done_cyc", done_cyc, 10);
        check("l0_rd_line",     rd_b, line_b);
`ifdef DDR_RESP_STATS_EN
        check("l0_stat_rd", rdc_b, 32'd1);
        check("l0_stat_wr", wrc_b, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
